// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The o_overflow signal exists only with SERIAL_SUBTRACTOR_OVERFLOW_EN.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             i_start;
    logic [WIDTH-1:0] i_minuend;
    logic [WIDTH-1:0] i_subtrahend;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_diff;
    logic             o_borrow;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    logic             o_overflow;

    modport master (
        output i_start, i_minuend, i_subtrahend,
        input  o_busy, o_done, o_diff, o_borrow, o_overflow
    );

    modport slave (
        input  i_start, i_minuend, i_subtrahend,
        output o_busy, o_done, o_diff, o_borrow, o_overflow
    );
`else
    modport master (
        output i_start, i_minuend, i_subtrahend,
        input  o_busy, o_done, o_diff, o_borrow
    );

    modport slave (
        input  i_start, i_minuend, i_subtrahend,
        output o_busy, o_done, o_diff, o_borrow
    );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first, one full-subtractor cell.
// Optional signed-overflow flag enabled by SERIAL_SUBTRACTOR_OVERFLOW_EN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    serial_subtractor_if.slave  bus
);

    if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
        $error("serial_subtractor: WIDTH must be in 2..32");
    end

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             accept;
    logic             step;
    logic             last;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-2:0] res_q;
    logic             br_q;
    logic [CW-1:0]    cnt_q;

    logic             d_bit;
    logic             br_nxt;
    logic [WIDTH-1:0] res_nxt;

    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;

    // Full-subtractor cell on the current operand LSBs.
    always_comb begin
        d_bit   = a_q[0] ^ b_q[0] ^ br_q;
        br_nxt  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
        res_nxt = {d_bit, res_q};
    end

    // Next-state and per-edge control decode.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    accept  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (cnt_q == LAST) begin
                    last    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand shifters, borrow flop and bit counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            br_q  <= 1'b0;
            cnt_q <= '0;
        end else if (accept) begin
            a_q   <= bus.i_minuend;
            b_q   <= bus.i_subtrahend;
            br_q  <= 1'b0;
            cnt_q <= '0;
        end else if (step) begin
            a_q   <= a_q >> 1;
            b_q   <= b_q >> 1;
            res_q <= res_nxt[WIDTH-1:1];
            br_q  <= br_nxt;
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // Result registers load only on the edge that enters DONE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else if (last) begin
            diff_q   <= res_nxt;
            borrow_q <= br_nxt;
        end
    end

    // Registered status flags follow the next state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= (state_d != IDLE);
            done_q <= (state_d == DONE);
        end
    end

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    logic a_msb_q;
    logic b_msb_q;
    logic ovf_q;

    // Original operand signs are kept since the shifters lose them.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
        end else if (accept) begin
            a_msb_q <= bus.i_minuend[WIDTH-1];
            b_msb_q <= bus.i_subtrahend[WIDTH-1];
        end
    end

    // Signed overflow: operand signs differ and result sign differs from A.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ovf_q <= 1'b0;
        end else if (last) begin
            ovf_q <= (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
        end
    end

    assign bus.o_overflow = ovf_q;
`endif

    assign bus.o_busy   = busy_q;
    assign bus.o_done   = done_q;
    assign bus.o_diff   = diff_q;
    assign bus.o_borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random bench for serial_subtractor (WIDTH=8).
// Builds with or without SERIAL_SUBTRACTOR_OVERFLOW_EN.
module tb_serial_subtractor;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [W-1:0] last_d = '0;
    logic         last_b = 1'b0;
    logic         last_o = 1'b0;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] d, output logic br,
                                  output logic ov);
        int sa;
        int sb;
        int sd;
        d  = W'((int'(a) - int'(b)) & 255);
        br = (int'(a) < int'(b));
        sa = int'($signed(a));
        sb = int'($signed(b));
        sd = sa - sb;
        ov = (sd < -128) || (sd > 127);
    endfunction

    task automatic check_results(input string tag, input logic [W-1:0] d,
                                 input logic br, input logic ov);
        chk({tag, ".diff"}, 32'(bus.o_diff), 32'(d));
        chk({tag, ".borrow"}, 32'(bus.o_borrow), 32'(br));
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        chk({tag, ".ovf"}, 32'(bus.o_overflow), 32'(ov));
`else
        if (ov !== 1'bx) begin end
`endif
    endtask

    // Call #1 after a rising edge with the DUT idle; returns #1 after E_WIDTH+1.
    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        logic [W-1:0] ed;
        logic         eb;
        logic         eo;
        int           lat;
        logic         hold_ok;
        model(a, b, ed, eb, eo);
        bus.i_start      = 1'b1;
        bus.i_minuend    = a;
        bus.i_subtrahend = b;
        @(posedge clk);
        #1;
        bus.i_start      = 1'b0;
        bus.i_minuend    = W'($urandom);
        bus.i_subtrahend = W'($urandom);
        lat     = 0;
        hold_ok = 1'b1;
        while (!bus.o_done && lat < 40) begin
            if (bus.o_diff !== last_d || bus.o_borrow !== last_b)
                hold_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, ".latency"}, 32'(lat), 32'(W));
        chk({tag, ".hold"}, 32'(hold_ok), 32'd1);
        chk({tag, ".busy"}, 32'(bus.o_busy), 32'd1);
        check_results(tag, ed, eb, eo);
        @(posedge clk);
        #1;
        chk({tag, ".done_pulse"}, 32'(bus.o_done), 32'd0);
        chk({tag, ".busy_fall"}, 32'(bus.o_busy), 32'd0);
        last_d = ed;
        last_b = eb;
        last_o = eo;
    endtask

    initial begin
        int           lat;
        int           gap;
        int           seen;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        bus.i_start      = 1'b0;
        bus.i_minuend    = '0;
        bus.i_subtrahend = '0;
        rst_n            = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.busy", 32'(bus.o_busy), 32'd0);
        chk("rst.done", 32'(bus.o_done), 32'd0);
        chk("rst.diff", 32'(bus.o_diff), 32'd0);
        chk("rst.borrow", 32'(bus.o_borrow), 32'd0);
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        chk("rst.ovf", 32'(bus.o_overflow), 32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        op(8'h05, 8'h03, "d05_03");
        op(8'h03, 8'h05, "d03_05");
        op(8'h80, 8'h01, "d80_01");
        op(8'h7F, 8'hFF, "d7f_ff");
        op(8'h5A, 8'h5A, "eq");
        op(8'hC3, 8'h00, "bzero");
        op(8'h00, 8'hFF, "d00_ff");

        // Start held high through SHIFT/DONE: second accept only at E10.
        bus.i_start      = 1'b1;
        bus.i_minuend    = 8'h10;
        bus.i_subtrahend = 8'h01;
        @(posedge clk);
        #1;
        bus.i_minuend    = 8'hFF;
        bus.i_subtrahend = 8'hFF;
        lat = 0;
        while (!bus.o_done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("hold1.latency", 32'(lat), 32'(W));
        check_results("hold1", 8'h0F, 1'b0, 1'b0);
        gap = 0;
        do begin
            @(posedge clk);
            #1;
            gap++;
            if (gap == 1)
                chk("hold.busy_gap", 32'(bus.o_busy), 32'd0);
            if (gap == 2)
                chk("hold.busy_rise", 32'(bus.o_busy), 32'd1);
        end while (!bus.o_done && gap < 40);
        bus.i_start = 1'b0;
        chk("hold.spacing", 32'(gap), 32'(W + 2));
        check_results("hold2", 8'h00, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        last_d = 8'h00;
        last_b = 1'b0;

        // Reset mid-operation aborts with no completion.
        bus.i_start      = 1'b1;
        bus.i_minuend    = 8'hAA;
        bus.i_subtrahend = 8'h55;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort.busy", 32'(bus.o_busy), 32'd0);
        chk("abort.done", 32'(bus.o_done), 32'd0);
        chk("abort.diff", 32'(bus.o_diff), 32'd0);
        chk("abort.borrow", 32'(bus.o_borrow), 32'd0);
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        chk("abort.ovf", 32'(bus.o_overflow), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (14) begin
            @(posedge clk);
            #1;
            if (bus.o_done)
                seen++;
        end
        chk("abort.no_done", 32'(seen), 32'd0);
        last_d = '0;
        last_b = 1'b0;
        op(8'h00, 8'h01, "after_abort");

        // Random operations back to back at minimum spacing.
        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if (i % 6 == 0)
                rb = ra;
            op(ra, rb, $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor for the ripple-carry arithmetic datapath. It computes minuend minus subtrahend one bit per clock, LSB first. It reuses a single full-subtractor cell with a registered borrow, which is the inverse operation of the team's combinational adder chain. It trades latency for area and sits beside the ripple-carry adder for use by control logic that can tolerate multi-cycle results.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..32
- i_clk  in  1  clock; all state changes on rising edge
- i_rst_n  in  1  reset; asynchronous, active-low
- i_start  in  1  request; sampled only in IDLE
- i_minuend  in  WIDTH  operand A; captured on the accepting edge
- i_subtrahend  in  WIDTH  operand B; captured on the accepting edge
- o_busy  out  1  high in SHIFT and DONE
- o_done  out  1  one-cycle pulse; result valid
- o_diff  out  WIDTH  A − B modulo 2^WIDTH; held until the next completion
- o_borrow  out  1  unsigned borrow-out; 1 iff A < B unsigned
- o_overflow  out  1  signed overflow; present only with the macro (see Configuration)

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE → SHIFT when i_start=1. On that edge:
  - Latch A and B into shift registers.
  - Clear the borrow flip-flop and the bit counter.
- SHIFT, each edge:
  - Form the bit: d = a0 ^ b0 ^ br.
  - Next borrow: br' = (~a0 & b0) | (~(a0 ^ b0) & br).
  - Shift d into the result register MSB-first so the LSB ends at bit 0.
  - Shift both operand registers right.
  - Increment the counter.
- SHIFT → DONE on the edge that processes bit WIDTH−1. On that edge:
  - Load o_diff from the completed result.
  - Load o_borrow from the final borrow.
- DONE → IDLE unconditionally on the next edge.
- i_start is ignored in SHIFT and DONE. There is no queueing. Operands may change freely after the accepting edge.
- o_diff, o_borrow and o_overflow update only on entry to DONE. They hold through the following IDLE and SHIFT periods.
- Reset values, all outputs: o_busy=0, o_done=0, o_diff=0, o_borrow=0, o_overflow=0. Internal reset values: state=IDLE, counter=0, borrow=0.
- Asserting reset mid-operation aborts immediately. The in-flight result is discarded and no o_done is produced.
- A=B gives o_diff=0 and o_borrow=0. B=0 gives o_diff=A and o_borrow=0.

## Timing
- The accepting edge is E0. Bits are processed on edges E1..E_WIDTH.
- o_done and the new results become visible after E_WIDTH, giving a latency of WIDTH cycles from the accepting edge.
- o_done is high for exactly one cycle, the DONE state.
- Earliest next acceptance is E_WIDTH+2, so throughput is one operation per WIDTH+2 cycles.
- o_busy rises after E0 and falls after E_WIDTH+1.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- SERIAL_SUBTRACTOR_OVERFLOW_EN defined:
  - The o_overflow port exists.
  - On entry to DONE it loads (A[MSB] != B[MSB]) && (D[MSB] != A[MSB]), where A and B are the original operands and D is the result.
  - The original operand MSBs are retained in dedicated flops.
- Undefined:
  - The o_overflow port and its flops are absent.
  - All other behaviour and timing are identical.

## Test plan
- WIDTH=8, A=0x05, B=0x03, pulse i_start → after 8 cycles o_done=1, o_diff=0x02, o_borrow=0, o_overflow=0.
- A=0x03, B=0x05 → o_diff=0xFE, o_borrow=1, o_overflow=0.
- A=0x80, B=0x01 (macro defined) → o_diff=0x7F, o_borrow=0, o_overflow=1. Rerun with the macro undefined: same o_diff/o_borrow, and the port is absent.
- Accept A=0x10, B=0x01, then hold i_start=1 with A=0xFF, B=0xFF through SHIFT/DONE → o_diff=0x0F and o_borrow=0 for the first pulse. The second operation is accepted only at E10 and yields o_diff=0x00, o_borrow=0.
- Start A=0xAA, B=0x55, drop i_rst_n at cycle 4 for one cycle → all outputs 0 immediately and no o_done. A fresh start with A=0x00, B=0x01 then gives o_diff=0xFF, o_borrow=1.
- Back-to-back operations at minimum spacing → o_done pulses exactly 10 cycles apart. o_busy stays low for exactly one cycle between operations.
